// File: rtl/count_display_pkg.sv
// Shared definitions for the count display: converter states, segment
// patterns (active-low, seg[0]=a .. seg[6]=g) and double-dabble helpers.
package count_display_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } conv_state_e;

    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Add 3 to a BCD nibble that will overflow past 9 on the next shift.
    function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

    // Apply the add-3 correction to all three scratch nibbles.
    function automatic logic [11:0] dd_adjust3(input logic [11:0] s);
        return {dd_adjust(s[11:8]), dd_adjust(s[7:4]), dd_adjust(s[3:0])};
    endfunction

endpackage

// File: rtl/count_display_seg7_decoder.sv
// Combinational BCD nibble to active-low 7-segment pattern decoder.
// Codes 10..15 cannot come from a valid conversion and decode to dark.
module seg7_decoder
    import count_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Digit lookup; anything outside 0..9 stays dark.
    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/count_display.sv
// Display stage for the 8-bit up/down counter: sequential double-dabble
// binary-to-BCD conversion plus a multiplexed 4-digit common-anode scan
// with optional leading-zero blanking. Slot 3 is never lit.
module count_display
    import count_display_pkg::*;
#(
    parameter int SCAN_DIV = 5000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  value,
    input  logic        blank,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [11:0] bcd,
    output logic        busy
);

    localparam int             PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(SCAN_DIV - 1);

    conv_state_e   state_q, state_d;
    logic [7:0]    sreg_q, sreg_d;
    logic [11:0]   scratch_q, scratch_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    last_value_q, last_value_d;
    logic          last_valid_q, last_valid_d;
    logic [11:0]   bcd_q, bcd_d;
    logic          busy_q, busy_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic [11:0]   adj_s;
    logic [19:0]   shift_s;
    logic [3:0]    digit_s;
    logic          lit_s;
    logic [6:0]    dec_seg_s;

    // Converter: start on a new value while idle, then eight adjust-and-shift steps.
    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        scratch_d    = scratch_q;
        cnt_d        = cnt_q;
        last_value_d = last_value_q;
        last_valid_d = last_valid_q;
        bcd_d        = bcd_q;
        busy_d       = busy_q;
        adj_s        = dd_adjust3(scratch_q);
        shift_s      = {adj_s, sreg_q} << 3'd1;
        case (state_q)
            ST_IDLE: begin
                if (!last_valid_q || (value != last_value_q)) begin
                    sreg_d       = value;
                    last_value_d = value;
                    scratch_d    = 12'h000;
                    cnt_d        = 3'd0;
                    last_valid_d = 1'b1;
                    state_d      = ST_SHIFT;
                    busy_d       = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                scratch_d = shift_s[19:8];
                sreg_d    = shift_s[7:0];
                cnt_d     = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    bcd_d   = shift_s[19:8];
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Scan timing: prescaler wraps every SCAN_DIV clocks and steps the slot index.
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        if (presc_q == PRESC_MAX) begin
            presc_d = {PW{1'b0}};
            idx_d   = idx_q + 2'd1;
        end else begin
            presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    // Slot contents: pick the digit for the current slot and decide if it is lit.
    always_comb begin
        digit_s = 4'd0;
        lit_s   = 1'b0;
        case (idx_q)
            2'd0: begin
                digit_s = bcd_q[3:0];
                lit_s   = 1'b1;
            end
            2'd1: begin
                digit_s = bcd_q[7:4];
                lit_s   = !BLANK_LZ || (bcd_q[11:8] != 4'd0) || (bcd_q[7:4] != 4'd0);
            end
            2'd2: begin
                digit_s = bcd_q[11:8];
                lit_s   = !BLANK_LZ || (bcd_q[11:8] != 4'd0);
            end
            default: begin
                digit_s = 4'd0;
                lit_s   = 1'b0;
            end
        endcase
    end

    seg7_decoder u_dec (
        .nibble (digit_s),
        .seg    (dec_seg_s)
    );

    // Drive pattern: dark slot or global blank turns the anodes and segments off.
    always_comb begin
        dp_d = 1'b1;
        if (blank || !lit_s) begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
        end else begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = dec_seg_s;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sreg_q       <= 8'h00;
            scratch_q    <= 12'h000;
            cnt_q        <= 3'd0;
            last_value_q <= 8'h00;
            last_valid_q <= 1'b0;
            bcd_q        <= 12'h000;
            busy_q       <= 1'b0;
            presc_q      <= {PW{1'b0}};
            idx_q        <= 2'd0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            scratch_q    <= scratch_d;
            cnt_q        <= cnt_d;
            last_value_q <= last_value_d;
            last_valid_q <= last_valid_d;
            bcd_q        <= bcd_d;
            busy_q       <= busy_d;
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = dp_q;
    assign bcd  = bcd_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_count_display.sv
// Bench for count_display with a fast scan (SCAN_DIV=4). A timeline model
// predicts every output each cycle; directed steps add literal expectations.
module tb_count_display;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  value;
    logic        blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [11:0] bcd;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000};

    count_display #(.SCAN_DIV(DIV), .BLANK_LZ(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .blank (blank),
        .an    (an),
        .seg   (seg),
        .dp    (dp),
        .bcd   (bcd),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Model state: displayed number, conversion countdown, scan position.
    int         m_num, m_last, m_cnt, m_idx, m_presc;
    bit         m_valid, m_busy;
    logic [3:0] m_an;
    logic [6:0] m_seg;

    function automatic logic [11:0] to_bcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic bit slot_lit(input int idx, input int n);
        if (idx == 0) return 1'b1;
        if (idx == 1) return (n / 100 != 0) || ((n / 10) % 10 != 0);
        if (idx == 2) return (n / 100 != 0);
        return 1'b0;
    endfunction

    function automatic int slot_digit(input int idx, input int n);
        if (idx == 0) return n % 10;
        if (idx == 1) return (n / 10) % 10;
        if (idx == 2) return n / 100;
        return 0;
    endfunction

    // Model update: conversion takes one idle clock plus eight busy clocks.
    always @(posedge clk) begin
        if (reset) begin
            m_num <= 0; m_last <= 0; m_cnt <= 0; m_valid <= 1'b0; m_busy <= 1'b0;
            m_idx <= 0; m_presc <= 0; m_an <= 4'hF; m_seg <= 7'h7F;
        end else begin
            if (m_cnt == 0) begin
                if (!m_valid || int'(value) != m_last) begin
                    m_last <= int'(value); m_valid <= 1'b1; m_cnt <= 8; m_busy <= 1'b1;
                end
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_num <= m_last; m_busy <= 1'b0;
                end
            end
            if (m_presc == DIV - 1) begin
                m_presc <= 0; m_idx <= (m_idx + 1) % 4;
            end else begin
                m_presc <= m_presc + 1;
            end
            if (blank || !slot_lit(m_idx, m_num)) begin
                m_an <= 4'hF; m_seg <= 7'h7F;
            end else begin
                m_an <= ~(4'b0001 << m_idx); m_seg <= pat[slot_digit(m_idx, m_num)];
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model_an",   32'(an),   32'(m_an));
            cmp("model_seg",  32'(seg),  32'(m_seg));
            cmp("model_bcd",  32'(bcd),  32'(to_bcd(m_num)));
            cmp("model_busy", 32'(busy), 32'(m_busy));
            cmp("model_dp",   32'(dp),   32'd1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic conv_check(input logic [7:0] v, input logic [11:0] old_b, input logic [11:0] new_b);
        int busy_seen;
        value = v;
        tick(1); cmp("conv_start_busy", 32'(busy), 32'd1);
        tick(7); cmp("conv_mid_busy", 32'(busy), 32'd1);
        cmp("conv_mid_bcd", 32'(bcd), 32'(old_b));
        tick(1); cmp("conv_end_busy", 32'(busy), 32'd0);
        cmp("conv_end_bcd", 32'(bcd), 32'(new_b));
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (busy) busy_seen++;
        end
        cmp("stable_no_busy", 32'(busy_seen), 32'd0);
    endtask

    initial begin
        bit s0, s1, s2, s3;
        reset = 1'b1; value = 8'd0; blank = 1'b0;
        tick(3);
        chk_en = 1'b1;
        cmp("reset_an", 32'(an), 32'hF);
        cmp("reset_seg", 32'(seg), 32'h7F);
        cmp("reset_bcd", 32'(bcd), 32'h000);
        cmp("reset_busy", 32'(busy), 32'd0);

        // Test 1: first idle cycle after reset converts value 0.
        reset = 1'b0;
        tick(1);
        cmp("t1_busy", 32'(busy), 32'd1);
        cmp("t1_an0", 32'(an), 32'b1110);
        cmp("t1_seg0", 32'(seg), 32'b1000000);
        tick(8);
        cmp("t1_bcd", 32'(bcd), 32'h000);
        cmp("t1_done", 32'(busy), 32'd0);
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (an != 4'b1110) cmp("t1_dark_slots", 32'(an), 32'hF);
        end

        // Test 2: 255 shows all three digits and the anodes walk.
        value = 8'd255;
        tick(1); cmp("t2_busy", 32'(busy), 32'd1);
        tick(8); cmp("t2_bcd", 32'(bcd), 32'h255);
        s0 = 0; s1 = 0; s2 = 0; s3 = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (an == 4'b1110) begin s0 = 1; cmp("t2_ones", 32'(seg), 32'b0010010); end
            else if (an == 4'b1101) begin s1 = 1; cmp("t2_tens", 32'(seg), 32'b0010010); end
            else if (an == 4'b1011) begin s2 = 1; cmp("t2_hund", 32'(seg), 32'b0100100); end
            else if (an == 4'b1111) s3 = 1;
            else cmp("t2_an_legal", 32'(an), 32'hF);
        end
        cmp("t2_walk_seen", {28'd0, s3, s2, s1, s0}, 32'hF);

        // Test 3: change during SHIFT is picked up after the current conversion.
        value = 8'd9;
        tick(1); cmp("t3_busy", 32'(busy), 32'd1);
        tick(2); value = 8'd100;
        tick(6);
        cmp("t3_bcd_first", 32'(bcd), 32'h009);
        cmp("t3_idle", 32'(busy), 32'd0);
        tick(1); cmp("t3_rebusy", 32'(busy), 32'd1);
        tick(8); cmp("t3_bcd_second", 32'(bcd), 32'h100);
        s1 = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (an == 4'b1101) begin s1 = 1; cmp("t3_tens_zero", 32'(seg), 32'b1000000); end
        end
        cmp("t3_tens_lit", 32'(s1), 32'd1);

        // Test 4: wrap transitions, each exactly nine clocks.
        conv_check(8'd255, 12'h100, 12'h255);
        conv_check(8'd0,   12'h255, 12'h000);
        conv_check(8'd255, 12'h000, 12'h255);

        // Test 5: reset in the middle of a conversion.
        value = 8'd77;
        tick(3);
        reset = 1'b1;
        tick(1);
        cmp("t5_busy", 32'(busy), 32'd0);
        cmp("t5_an", 32'(an), 32'hF);
        cmp("t5_bcd", 32'(bcd), 32'h000);
        reset = 1'b0;
        tick(1); cmp("t5_restart", 32'(busy), 32'd1);
        tick(8); cmp("t5_bcd_done", 32'(bcd), 32'h077);

        // Test 6: blank for three slots while a conversion runs.
        blank = 1'b1; value = 8'd123;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            cmp("t6_blank_an", 32'(an), 32'hF);
        end
        cmp("t6_bcd", 32'(bcd), 32'h123);
        blank = 1'b0;
        tick(16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
